// File: rtl/cgra_stream_pkg.sv
// Shared types and buffer sizing for the CGRA stream loader.
package cgra_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} loader_state_t;
  localparam int BUF_DEPTH = 4;
  localparam int BUF_PTR_W = 2;
endpackage

// File: rtl/cgra_stream_buf.sv
// 4-entry FIFO between scratchpad return data and the output stream.
// The head entry is presented straight from the storage registers, so dout/dout_v never depend on dout_r.
module cgra_stream_buf import cgra_stream_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_v,
  input  logic                  dout_r,
  output logic [BUF_PTR_W:0]    occupancy
);
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [BUF_PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [BUF_PTR_W:0]    count;
  logic                  pop;

  assign pop       = dout_v & dout_r;
  assign dout_v    = (count != '0);
  assign dout      = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (BUF_PTR_W+1)'(wr_en) - (BUF_PTR_W+1)'(pop);
    end
  end
endmodule

// File: rtl/cgra_stream_loader.sv
// Strided scratchpad reader feeding a valid/ready stream; reads are credit-limited
// so buffered plus in-flight words never exceed the buffer depth.
module cgra_stream_loader import cgra_stream_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_v,
  input  logic                  dout_r
);
  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  len_q, issued;
  // [0]: read on the scratchpad port this cycle, [1]: its data returns this cycle
  logic [1:0]            vld_pipe;
  logic [BUF_PTR_W:0]    occ, outstanding;
  logic                  credit_ok, last_pop;

  assign mem_rd_en   = vld_pipe[0];
  // Uses current occupancy only (ignores a pop this cycle) to keep dout_r out of the read path.
  assign outstanding = occ + (BUF_PTR_W+1)'(vld_pipe[0]) + (BUF_PTR_W+1)'(vld_pipe[1]);
  assign credit_ok   = outstanding < (BUF_PTR_W+1)'(BUF_DEPTH);
  assign last_pop    = (state == DRAIN) && dout_v && dout_r &&
                       (occ == (BUF_PTR_W+1)'(1)) && (vld_pipe == 2'b00);

  cgra_stream_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (vld_pipe[1]),
    .wr_data   (mem_rd_data),
    .dout      (dout),
    .dout_v    (dout_v),
    .dout_r    (dout_r),
    .occupancy (occ)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      vld_pipe <= 2'b00;
      mem_addr <= '0;
      stride_q <= '0;
      len_q    <= '0;
      issued   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], 1'b0};
      done     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          stride_q <= stride;
          len_q    <= length;
          if (length == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state       <= RUN;
            busy        <= 1'b1;
            vld_pipe[0] <= 1'b1;
            mem_addr    <= base_addr;
            issued      <= LEN_WIDTH'(1);
          end
        end
        RUN: begin
          if (issued == len_q) begin
            state <= DRAIN;
          end else if (credit_ok) begin
            vld_pipe[0] <= 1'b1;
            mem_addr    <= mem_addr + stride_q;
            issued      <= issued + 1'b1;
          end
        end
        DRAIN: if (last_pop) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cgra_stream_loader.sv
// Randomized bench for cgra_stream_loader: a queue-based reference of the expected
// address/data sequence is checked against the memory port and the output stream.
module tb_cgra_stream_loader;
  localparam int DW = 32, AW = 10, LW = 16;

  logic          clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0, stride = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, mem_rd_en, dout_v;
  logic          dout_r = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0, dout;

  always #5 clock = ~clock;

  cgra_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .stride(stride), .length(length), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .dout(dout), .dout_v(dout_v), .dout_r(dout_r)
  );

  logic [DW-1:0] mem [1024];
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  int            addr_q[$];
  int            n_iss = 0, n_hs = 0, n_done = 0;
  logic          prev_v = 1'b0, prev_r = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge clock) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_v", dout_v, 1);
        chk("hold_d", dout, prev_d);
      end
      if (mem_rd_en) begin
        n_iss++;
        if (addr_q.size() == 0) chk("extra_rd", 1, 0);
        else chk("rd_addr", mem_addr, addr_q.pop_front());
        chk("credit", (n_iss - n_hs) <= 4, 1);
      end
      if (dout_v && dout_r) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else chk("dout", dout, exp_q.pop_front());
        n_hs++;
      end
      if (done) n_done++;
      prev_v = dout_v; prev_r = dout_r; prev_d = dout;
    end
  end

  function automatic logic rdy(input int mode, input int c, input int stall);
    case (mode)
      0:       return 1'b1;
      1:       return c >= stall;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic load_ref(input int base, input int st, input int len);
    for (int k = 0; k < len; k++) begin
      int a;
      a = (base + k * st) % 1024;
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
    end
  endtask

  // Runs one transfer from IDLE; restart>0 pulses a conflicting start in that cycle.
  task automatic xfer(input int base, input int st, input int len,
                      input int mode, input int stall, input int restart);
    int done_cyc, first_rd, first_v, d0;
    done_cyc = -1; first_rd = -1; first_v = -1; d0 = n_done;
    load_ref(base, st, len);
    base_addr = AW'(base); stride = AW'(st); length = LW'(len);
    start = 1'b1;
    dout_r = rdy(mode, 0, stall);
    for (int c = 1; c <= 3000 && done_cyc < 0; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (c == restart) begin
        start = 1'b1; base_addr = base_addr + AW'(100); length = LW'(5);
      end
      if (mem_rd_en && first_rd < 0) first_rd = c;
      if (dout_v && first_v < 0) first_v = c;
      if (done) begin
        done_cyc = c;
        chk("busy_at_done", busy, 0);
      end else chk("busy_run", busy, len != 0);
      dout_r = rdy(mode, c, stall);
    end
    start = 1'b0;
    if (done_cyc < 0) chk("timeout", 0, 1);
    if (mode == 0) begin
      if (len == 0) begin
        chk("len0_done_cyc", done_cyc, 1);
        chk("len0_no_rd", first_rd, -1);
        chk("len0_no_v", first_v, -1);
      end else begin
        chk("first_rd_cyc", first_rd, 1);
        chk("first_v_cyc", first_v, 3);
        chk("done_cyc", done_cyc, len + 3);
      end
    end
    @(posedge clock); #1;
    chk("done_fall", done, 0);
    chk("busy_idle", busy, 0);
    chk("words_left", exp_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
    chk("done_count", n_done - d0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dout_v"}, dout_v, 0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'(a * 3);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("rst");
    reset = 1'b0;

    xfer(10, 1, 4, 0, 0, 0);
    xfer(10, 1, 4, 1, 10, 0);
    xfer(1022, 3, 3, 0, 0, 0);
    xfer(0, 5, 0, 0, 0, 0);

    // Abort a length-8 transfer with reset in cycle 4.
    load_ref(20, 2, 8);
    base_addr = AW'(20); stride = AW'(2); length = LW'(8);
    start = 1'b1; dout_r = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    chk_zero("abort");
    reset = 1'b0;
    addr_q.delete(); exp_q.delete();
    n_iss = 0; n_hs = 0;
    repeat (2) begin
      @(posedge clock); #1;
      chk("abort_quiet_v", dout_v, 0);
      chk("abort_quiet_done", done, 0);
    end
    xfer(300, 7, 2, 0, 0, 0);

    xfer(40, 2, 6, 0, 0, 2);

    for (int a = 0; a < 1024; a++) mem[a] = $urandom;
    for (int i = 0; i < 14; i++)
      xfer($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 20),
           $urandom_range(0, 2), $urandom_range(0, 15), 0);
    xfer($urandom_range(0, 1023), $urandom_range(1, 9), 45, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
